pdh_gpio_cmd_ctrl: RTL and testbench



---
 rtl/pdh_ctrl_pkg.sv | 47 ++++
 rtl/pdh_word_sync.sv | 30 +++
 rtl/pdh_gpio_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pdh_gpio_cmd_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pdh_ctrl_pkg.sv
// Shared definitions for the PS <-> pdh_clk command sequencer: word layouts, opcodes, FSM states.
package pdh_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RSVD_W = 8;

    // Command word (PS -> PL)
    localparam int unsigned IN_STROBE_BIT = 31;
    localparam int unsigned IN_OP_LSB     = 27;
    localparam int unsigned IN_ADDR_LSB   = 24;
    localparam int unsigned IN_RSVD_LSB   = 16;
    localparam int unsigned IN_DATA_LSB   = 0;
    localparam logic [WORD_W-1:0] IN_RSVD_MASK = 32'h00FF_0000;

    // Response word (PL -> PS)
    localparam int unsigned OUT_ACK_BIT  = 31;
    localparam int unsigned OUT_ERR_BIT  = 30;
    localparam int unsigned OUT_BUSY_BIT = 29;
    localparam int unsigned OUT_ADDR_LSB = 24;
    localparam int unsigned OUT_CNT_LSB  = 16;
    localparam int unsigned OUT_DATA_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 4'd0,
        OP_WRITE  = 4'd1,
        OP_READ   = 4'd2,
        OP_STATUS = 4'd3,
        OP_SRST   = 4'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        EXEC   = 3'd2,
        SRST   = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Opcodes above OP_SRST are reserved and reported as errors.
    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return op <= OP_SRST;
    endfunction

endpackage

// File: rtl/pdh_word_sync.sv
// Two-flop bus synchroniser with a one-cycle-delayed copy for change detection.
module pdh_word_sync #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] word_in,
    output logic [W-1:0] sync_word,
    output logic         changed_c
);

    logic [W-1:0] meta;
    logic [W-1:0] prev;

    // Synchroniser chain plus previous-cycle copy of the synchronised word
    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= '0;
            sync_word <= '0;
            prev      <= '0;
        end else begin
            meta      <= word_in;
            sync_word <= meta;
            prev      <= sync_word;
        end
    end

    assign changed_c = (sync_word != prev);

endmodule

// File: rtl/pdh_gpio_cmd_ctrl.sv
// Command sequencer: decodes toggle-strobe PS commands, owns the datapath config registers.
module pdh_gpio_cmd_ctrl
    import pdh_ctrl_pkg::*;
#(
    parameter int unsigned N_REGS          = 8,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned SOFT_RST_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        axi_from_ps_i,
    output logic [WORD_W-1:0]        axi_to_ps_o,
    input  logic [DATA_W-1:0]        status_i,
    output logic [N_REGS*DATA_W-1:0] cfg_regs_o,
    output logic                     cfg_wr_o,
    output logic [ADDR_W-1:0]        cfg_wr_addr_o,
    output logic                     soft_rst_o
);

    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned SRST_W   = 8;

    logic [WORD_W-1:0] sync_word;
    logic              word_changed_c;
    logic              sync_rsvd_unused;

    state_e            state;
    state_e            state_next;
    logic              last_strobe;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SRST_W-1:0] srst_cnt;

    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cfg_regs [N_REGS];

    logic [DATA_W-1:0] exec_rd;
    logic              exec_err;
    logic              ack;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] rsp_addr;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [DATA_W-1:0] rsp_data;

    logic              latch_c;
    logic              exec_c;
    logic              resp_c;
    logic              wr_c;
    logic              err_c;
    logic [DATA_W-1:0] rd_c;

    // Reserved bits are masked before synchronisation so they never restart settling
    pdh_word_sync #(.W(WORD_W)) u_word_sync (
        .clk       (clk),
        .rst       (rst),
        .word_in   (axi_from_ps_i & ~IN_RSVD_MASK),
        .sync_word (sync_word),
        .changed_c (word_changed_c)
    );

    assign sync_rsvd_unused = ^sync_word[IN_RSVD_LSB +: RSVD_W];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sync_word[IN_STROBE_BIT] != last_strobe) state_next = SETTLE;
            SETTLE:  if (!word_changed_c && settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) state_next = EXEC;
            EXEC:    state_next = (cmd_op == OP_SRST) ? SRST : RESP;
            SRST:    if (srst_cnt == SRST_W'(SOFT_RST_CYCLES - 1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output decode: stage enables and the read data a command returns
    always_comb begin
        latch_c = 1'b0;
        exec_c  = 1'b0;
        resp_c  = 1'b0;
        wr_c    = 1'b0;
        err_c   = 1'b0;
        rd_c    = '0;
        latch_c = (state == SETTLE) && (state_next == EXEC);
        exec_c  = (state == EXEC);
        resp_c  = (state == RESP);
        wr_c    = exec_c && (cmd_op == OP_WRITE);
        err_c   = !op_is_valid(cmd_op);
        case (cmd_op)
            OP_WRITE:  rd_c = cmd_data;
            OP_READ:   rd_c = cfg_regs[cmd_addr];
            OP_STATUS: rd_c = status_i;
            default:   rd_c = '0;
        endcase
    end

    // Counters, command capture, register file and response fields
    always_ff @(posedge clk) begin
        if (rst) begin
            last_strobe   <= 1'b0;
            settle_cnt    <= '0;
            srst_cnt      <= '0;
            cmd_op        <= '0;
            cmd_addr      <= '0;
            cmd_data      <= '0;
            for (int unsigned k = 0; k < N_REGS; k++) cfg_regs[k] <= '0;
            cfg_wr_o      <= 1'b0;
            cfg_wr_addr_o <= '0;
            soft_rst_o    <= 1'b0;
            exec_rd       <= '0;
            exec_err      <= 1'b0;
            ack           <= 1'b0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
            rsp_addr      <= '0;
            cmd_cnt       <= '0;
            rsp_data      <= '0;
        end else begin
            settle_cnt <= (state == SETTLE && !word_changed_c) ? settle_cnt + SETTLE_W'(1) : '0;
            srst_cnt   <= (state == SRST) ? srst_cnt + SRST_W'(1) : '0;
            soft_rst_o <= (state_next == SRST);
            busy       <= (state_next != IDLE);
            cfg_wr_o   <= wr_c;
            if (latch_c) begin
                cmd_op      <= sync_word[IN_OP_LSB +: OP_W];
                cmd_addr    <= sync_word[IN_ADDR_LSB +: ADDR_W];
                cmd_data    <= sync_word[IN_DATA_LSB +: DATA_W];
                last_strobe <= sync_word[IN_STROBE_BIT];
            end
            if (wr_c) begin
                cfg_regs[cmd_addr] <= cmd_data;
                cfg_wr_addr_o      <= cmd_addr;
            end
            if (exec_c) begin
                exec_rd  <= rd_c;
                exec_err <= err_c;
            end
            if (resp_c) begin
                ack      <= last_strobe;
                rsp_err  <= exec_err;
                rsp_addr <= cmd_addr;
                rsp_data <= exec_rd;
                cmd_cnt  <= cmd_cnt + CNT_W'(1);
            end
        end
    end

    assign axi_to_ps_o = {ack, rsp_err, busy, 2'b00, rsp_addr, cmd_cnt, rsp_data};

    // Flatten the register file, register k at [16k+15:16k]
    always_comb begin
        cfg_regs_o = '0;
        for (int unsigned k = 0; k < N_REGS; k++) cfg_regs_o[k*DATA_W +: DATA_W] = cfg_regs[k];
    end

endmodule

// File: tb/tb_pdh_gpio_cmd_ctrl.sv
// Scoreboard bench for pdh_gpio_cmd_ctrl: directed commands, queued expected responses.
module tb_pdh_gpio_cmd_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  axi_from_ps_i = 32'h0;
    logic [31:0]  axi_to_ps_o;
    logic [15:0]  status_i = 16'h0;
    logic [127:0] cfg_regs_o;
    logic         cfg_wr_o;
    logic [2:0]   cfg_wr_addr_o;
    logic         soft_rst_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_rsp_q [$];
    logic [2:0]  exp_wr_q  [$];
    logic        strobe    = 1'b0;
    logic [7:0]  cnt_model = 8'h00;
    logic [7:0]  prev_cnt  = 8'h00;
    logic [31:0] mon_exp;
    logic [2:0]  mon_addr;
    int          srst_run  = 0;
    int          srst_len  = 0;
    logic [127:0] exp_regs = '0;

    pdh_gpio_cmd_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .axi_from_ps_i (axi_from_ps_i),
        .axi_to_ps_o   (axi_to_ps_o),
        .status_i      (status_i),
        .cfg_regs_o    (cfg_regs_o),
        .cfg_wr_o      (cfg_wr_o),
        .cfg_wr_addr_o (cfg_wr_addr_o),
        .soft_rst_o    (soft_rst_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitor: a response is presented whenever the cmd count field moves
    always @(negedge clk) begin
        if (rst) begin
            prev_cnt = 8'h00;
        end else begin
            if (axi_to_ps_o[23:16] != prev_cnt) begin
                prev_cnt = axi_to_ps_o[23:16];
                if (exp_rsp_q.size() == 0) fail_now("unexpected_response");
                else begin
                    mon_exp = exp_rsp_q.pop_front();
                    check("response", 128'(axi_to_ps_o), 128'(mon_exp));
                end
            end
            if (cfg_wr_o) begin
                if (exp_wr_q.size() == 0) fail_now("unexpected_cfg_wr");
                else begin
                    mon_addr = exp_wr_q.pop_front();
                    check("cfg_wr_addr", 128'(cfg_wr_addr_o), 128'(mon_addr));
                end
            end
        end
        if (soft_rst_o) srst_run++;
        else begin
            if (srst_run != 0) srst_len = srst_run;
            srst_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, push its expected response, wait (bounded) for the ack toggle
    task automatic issue(input logic [3:0] op, input logic [2:0] addr, input logic [15:0] data,
                         input logic [15:0] exp_rd, input logic exp_err,
                         input bit glitch, input logic [15:0] data2, input int exp_lat);
        int n;
        bit got;
        strobe    = ~strobe;
        cnt_model = cnt_model + 8'd1;
        exp_rsp_q.push_back({strobe, exp_err, 1'b0, 2'b00, addr, cnt_model, exp_rd});
        if (op == 4'd1) exp_wr_q.push_back(addr);
        axi_from_ps_i = {strobe, op, addr, 8'h00, data};
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            tick();
            n++;
            if (glitch && n == 2) axi_from_ps_i[15:0] = data2;
            if (axi_to_ps_o[31] == strobe) got = 1'b1;
        end
        if (!got) fail_now("ack_timeout");
        else if (exp_lat != 0) check("ack_latency", 128'(n), 128'(exp_lat));
        repeat (3) tick();
    endtask

    initial begin
        int n;
        bit got;

        // Reset state
        repeat (3) tick();
        check("rst_axi_to_ps", 128'(axi_to_ps_o), 128'h0);
        check("rst_cfg_regs", cfg_regs_o, 128'h0);
        check("rst_cfg_wr", 128'(cfg_wr_o), 128'h0);
        check("rst_cfg_wr_addr", 128'(cfg_wr_addr_o), 128'h0);
        check("rst_soft_rst", 128'(soft_rst_o), 128'h0);
        rst = 1'b0;
        repeat (2) tick();

        // WRITE addr 0: word 0x8800_1234, response 0x8001_1234 after 9 cycles
        issue(4'd1, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0, 9);
        exp_regs[15:0] = 16'h1234;
        check("regs_after_write0", cfg_regs_o, exp_regs);

        // WRITE addr 5 then READ it back
        issue(4'd1, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'h0, 9);
        exp_regs[95:80] = 16'hBEEF;
        issue(4'd2, 3'd5, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0, 9);

        // Invalid opcode: err, no write, registers unchanged; NOP clears err
        issue(4'hF, 3'd2, 16'h5555, 16'h0000, 1'b1, 1'b0, 16'h0, 9);
        check("regs_after_invalid", cfg_regs_o, exp_regs);
        issue(4'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 9);

        // READ_STATUS samples status_i
        status_i = 16'hA5C3;
        issue(4'd3, 3'd7, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 16'h0, 9);

        // Data changes two cycles after the strobe edge: settle restarts, later value captured
        issue(4'd1, 3'd3, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h2222, 11);
        exp_regs[63:48] = 16'h2222;
        check("regs_after_glitch", cfg_regs_o, exp_regs);

        // SOFT_RESET: 16-cycle pulse, registers preserved
        issue(4'd4, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 25);
        check("soft_rst_len", 128'(srst_len), 128'd16);
        check("regs_after_srst", cfg_regs_o, exp_regs);

        // Double strobe toggle while busy in SRST is merged away
        strobe    = ~strobe;
        cnt_model = cnt_model + 8'd1;
        exp_rsp_q.push_back({strobe, 1'b0, 1'b0, 2'b00, 3'd0, cnt_model, 16'h0000});
        axi_from_ps_i = {strobe, 4'd4, 3'd0, 8'h00, 16'h0000};
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            tick();
            n++;
            if (n == 14) axi_from_ps_i[31] = ~strobe;
            if (n == 18) axi_from_ps_i[31] = strobe;
            if (axi_to_ps_o[31] == strobe) got = 1'b1;
        end
        if (!got) fail_now("merged_ack_timeout");
        else check("merged_ack_latency", 128'(n), 128'd25);
        repeat (40) tick();
        check("merged_busy_clear", 128'(axi_to_ps_o[29]), 128'h0);
        check("merged_no_extra", 128'(exp_rsp_q.size()), 128'h0);
        issue(4'd0, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 9);

        // Command counter wraps 255 -> 0
        while (cnt_model != 8'hFF) issue(4'd0, 3'(cnt_model), 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 9);
        issue(4'd0, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 9);
        check("cmd_count_wrap", 128'(axi_to_ps_o[23:16]), 128'h0);

        // rst during a soft reset truncates the pulse and clears everything
        strobe = ~strobe;
        axi_from_ps_i = {strobe, 4'd4, 3'd0, 8'h00, 16'h0000};
        n = 0;
        while (!soft_rst_o && n < 50) begin
            tick();
            n++;
        end
        if (!soft_rst_o) fail_now("srst_start_timeout");
        repeat (5) tick();
        rst = 1'b1;
        axi_from_ps_i = 32'h0;
        tick();
        check("midrst_soft_rst", 128'(soft_rst_o), 128'h0);
        check("midrst_axi_to_ps", 128'(axi_to_ps_o), 128'h0);
        check("midrst_cfg_regs", cfg_regs_o, 128'h0);
        check("midrst_cfg_wr", 128'(cfg_wr_o), 128'h0);
        check("midrst_cfg_wr_addr", 128'(cfg_wr_addr_o), 128'h0);
        tick();
        rst       = 1'b0;
        strobe    = 1'b0;
        cnt_model = 8'h00;
        repeat (3) tick();

        // After reset the register file reads back zero and the count restarts at 1
        issue(4'd2, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 9);

        repeat (5) tick();
        check("pending_responses", 128'(exp_rsp_q.size()), 128'h0);
        check("pending_cfg_writes", 128'(exp_wr_q.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
